mem_bank_responder: RTL and testbench

- Memory-side responder for the CPU's instruction-fetch, data-read and data-write ports; one instance per bank, 16 instances cover the 64 KiB byte space.
- Serves two independent read ports with fixed 2-cycle latency, matching the CPU's two wait stages and two read-mem stages, plus one write port.
- Outputs are gated by a bank hit, so instances OR-combine onto the shared CPU buses with no multi-driver conflict.

---
 rtl/mem_pkg.sv | 32 +++
 rtl/mem_read_pipe.sv | 57 +++++
 rtl/mem_bank_responder.sv | 103 ++++++++++
 tb/tb_mem_bank_responder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared widths, address-field slices and FSM states for the memory bank responder.
package mem_pkg;

    localparam int ADDR_W     = 15;
    localparam int DATA_W     = 16;
    localparam int BANK_SEL_W = 4;
    localparam int OFFSET_W   = 11;

    // Word address bit i is byte address bit i+1.
    localparam int BANK_HI = ADDR_W - 1;
    localparam int BANK_LO = OFFSET_W;
    localparam int OFF_HI  = OFFSET_W - 1;
    localparam int OFF_LO  = 0;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    function automatic logic [BANK_SEL_W-1:0] bank_of(
        input logic [ADDR_W-1:0] a
    );
        return a[BANK_HI:BANK_LO];
    endfunction

    function automatic logic [OFFSET_W-1:0] offset_of(
        input logic [ADDR_W-1:0] a
    );
        return a[OFF_HI:OFF_LO];
    endfunction

endpackage

// File: rtl/mem_read_pipe.sv
// Two-stage read pipe: registers address/hit, then captures the array word.
// MEM_BANK_WRITE_BYPASS_EN forwards a same-cycle hitting write into stage 2.
module mem_read_pipe
    import mem_pkg::*;
#(
    parameter logic [BANK_SEL_W-1:0] BANK_ID = '0,
    parameter int                    AW      = OFFSET_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ready,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr_hit,
    input  logic [AW-1:0]     wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    output logic [AW-1:0]     rd_idx,
    input  logic [DATA_W-1:0] mem_word,
    output logic [DATA_W-1:0] data,
    output logic              hit
);

    logic [AW-1:0]     idx_q;
    logic              hit_q;
    logic [DATA_W-1:0] data_q;
    logic              hit2_q;
    logic [DATA_W-1:0] word;
    logic [OFFSET_W-1:0] off;

    assign off    = offset_of(addr);
    assign rd_idx = idx_q;

`ifdef MEM_BANK_WRITE_BYPASS_EN
    assign word = (hit_q && wr_hit && wr_idx == idx_q) ? wr_data : mem_word;
`else
    logic unused_bypass;
    assign unused_bypass = ^{wr_hit, wr_idx, wr_data};
    assign word = mem_word;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            hit_q  <= 1'b0;
            data_q <= '0;
            hit2_q <= 1'b0;
        end else begin
            idx_q  <= off[AW-1:0];
            hit_q  <= (bank_of(addr) == BANK_ID) && ready;
            data_q <= word;
            hit2_q <= hit_q;
        end
    end

    assign data = data_q & {DATA_W{hit2_q}};
    assign hit  = hit2_q;

endmodule

// File: rtl/mem_bank_responder.sv
// One 4 KiB bank of the CPU memory: two 2-cycle read ports, one write port.
// MEM_BANK_WRITE_BYPASS_EN makes reads see a write landing on their stage-2 edge.
module mem_bank_responder
    import mem_pkg::*;
#(
    parameter logic [BANK_SEL_W-1:0] BANK_ID   = 4'd0,
    parameter int                    DEPTH     = 2048,
    parameter string                 INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_hit,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_hit,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              ready
);

    localparam int            AW         = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST       = AW'(DEPTH - 1);
    localparam logic          SKIP_CLEAR = (INIT_FILE != "");

    logic [DATA_W-1:0] mem [DEPTH];

    state_e            state;
    logic [AW-1:0]     cnt;
    logic              clr_we;
    logic              wr_hit;
    logic [AW-1:0]     wr_idx;
    logic [AW-1:0]     f_idx;
    logic [AW-1:0]     r_idx;
    logic [DATA_W-1:0] f_word;
    logic [DATA_W-1:0] r_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SKIP_CLEAR ? READY : CLEAR;
            cnt   <= '0;
        end else if (state == CLEAR) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
                state <= READY;
            end
        end
    end

    assign ready  = (state == READY);
    assign clr_we = rst_n && (state == CLEAR);
    assign wr_hit = wr_en && (bank_of(wr_addr) == BANK_ID) && ready;
    assign wr_idx = wr_addr[AW-1:0];

    // The sweep owns the array until READY, so stray writes are dropped.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[cnt] <= '0;
        end else if (wr_hit) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign f_word = mem[f_idx];
    assign r_word = mem[r_idx];

    mem_read_pipe #(
        .BANK_ID (BANK_ID),
        .AW      (AW)
    ) u_fetch_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .ready    (ready),
        .addr     (fetch_addr),
        .wr_hit   (wr_hit),
        .wr_idx   (wr_idx),
        .wr_data  (wr_data),
        .rd_idx   (f_idx),
        .mem_word (f_word),
        .data     (fetch_data),
        .hit      (fetch_hit)
    );

    mem_read_pipe #(
        .BANK_ID (BANK_ID),
        .AW      (AW)
    ) u_data_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .ready    (ready),
        .addr     (rd_addr),
        .wr_hit   (wr_hit),
        .wr_idx   (wr_idx),
        .wr_data  (wr_data),
        .rd_idx   (r_idx),
        .mem_word (r_word),
        .data     (rd_data),
        .hit      (rd_hit)
    );

endmodule

// File: tb/tb_mem_bank_responder.sv
// Randomised bench for mem_bank_responder (bank 3) with a transaction-level
// memory model; directed cases cover clear latency, gating and collisions.
module tb_mem_bank_responder;

    localparam logic [3:0] BANK  = 4'd3;
    localparam int         DEPTH = 2048;
`ifdef MEM_BANK_WRITE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [14:0] fetch_addr = '0;
    logic [15:0] fetch_data;
    logic        fetch_hit;
    logic [14:0] rd_addr = '0;
    logic [15:0] rd_data;
    logic        rd_hit;
    logic        wr_en = 1'b0;
    logic [14:0] wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        ready;

    mem_bank_responder #(
        .BANK_ID   (BANK),
        .DEPTH     (DEPTH),
        .INIT_FILE ("")
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fetch_addr (fetch_addr),
        .fetch_data (fetch_data),
        .fetch_hit  (fetch_hit),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_hit     (rd_hit),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .ready      (ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: word contents as the CPU would see them.
    logic [15:0] model [DEPTH];
    bit          m_ready;
    int          m_cnt;
    bit          p_rd_hit, p_fe_hit;
    logic [10:0] p_rd_idx, p_fe_idx;
    bit          e_rd_hit, e_fe_hit;
    logic [15:0] e_rd_data, e_fe_data;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ready  = 1'b0;
        m_cnt    = 0;
        p_rd_hit = 1'b0;
        p_fe_hit = 1'b0;
        p_rd_idx = '0;
        p_fe_idx = '0;
        e_rd_hit = 1'b0;
        e_fe_hit = 1'b0;
        e_rd_data = '0;
        e_fe_data = '0;
    endtask

    // Value returned two cycles after a read: array contents after the
    // previous edge, or the colliding write when forwarding is built in.
    function automatic logic [15:0] predict(input bit h, input logic [10:0] idx,
                                            input bit wh, input logic [10:0] widx,
                                            input logic [15:0] wd);
        if (!h) return 16'h0;
        if (BYPASS && wh && widx == idx) return wd;
        return model[idx];
    endfunction

    task automatic step(input bit we, input logic [14:0] wa,
                        input logic [15:0] wd, input logic [14:0] ra,
                        input logic [14:0] fa);
        bit wh;
        wr_en      = we;
        wr_addr    = wa;
        wr_data    = wd;
        rd_addr    = ra;
        fetch_addr = fa;
        wh = we && (wa[14:11] == BANK) && m_ready;
        e_rd_hit  = p_rd_hit;
        e_rd_data = predict(p_rd_hit, p_rd_idx, wh, wa[10:0], wd);
        e_fe_hit  = p_fe_hit;
        e_fe_data = predict(p_fe_hit, p_fe_idx, wh, wa[10:0], wd);
        p_rd_hit = (ra[14:11] == BANK) && m_ready;
        p_rd_idx = ra[10:0];
        p_fe_hit = (fa[14:11] == BANK) && m_ready;
        p_fe_idx = fa[10:0];
        if (wh) model[wa[10:0]] = wd;
        @(posedge clk);
        if (!m_ready) begin
            m_cnt++;
            if (m_cnt == DEPTH) begin
                m_ready = 1'b1;
                for (int i = 0; i < DEPTH; i++) model[i] = '0;
            end
        end
        @(negedge clk);
        chk("ready", 32'(ready), 32'(m_ready));
        chk("rd_hit", 32'(rd_hit), 32'(e_rd_hit));
        chk("rd_data", 32'(rd_data), 32'(e_rd_data));
        chk("fetch_hit", 32'(fetch_hit), 32'(e_fe_hit));
        chk("fetch_data", 32'(fetch_data), 32'(e_fe_data));
    endtask

    task automatic idle();
        step(1'b0, '0, '0, '0, '0);
    endtask

    function automatic logic [14:0] rnd_addr();
        logic [14:0] a;
        a = 15'($urandom);
        if ($urandom_range(3) != 0) a = {BANK, 6'd0, 5'($urandom)};
        return a;
    endfunction

    task automatic rnd_step();
        step(1'($urandom_range(1)), rnd_addr(), 16'($urandom),
             rnd_addr(), rnd_addr());
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        wr_en = 1'b0;
        #1;
        chk("rst_rd_hit", 32'(rd_hit), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_fetch_hit", 32'(fetch_hit), 32'd0);
        chk("rst_fetch_data", 32'(fetch_data), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Counts cycles from reset release to ready; slips in one write at an
    // already-swept word that must be dropped.
    task automatic wait_ready(input string tag, input int pre);
        int n = pre;
        while (!ready && n < 3000) begin
            if (n == 150)
                step(1'b1, 15'h1805, 16'h5555, rnd_addr(), rnd_addr());
            else
                rnd_step();
            n++;
        end
        chk(tag, 32'(n), 32'(DEPTH));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        do_reset();
        wait_ready("ready_latency", 0);

        step(1'b0, '0, '0, 15'h1800, '0);
        idle();
        chk("clear_rd_data", 32'(rd_data), 32'h0);
        chk("clear_rd_hit", 32'(rd_hit), 32'h1);

        step(1'b0, '0, '0, 15'h1805, '0);
        idle();
        chk("clear_write_lost", 32'(rd_data), 32'h0);

        step(1'b1, 15'h1805, 16'hBEEF, '0, '0);
        step(1'b0, '0, '0, 15'h1805, 15'h1805);
        idle();
        chk("wr_rd", 32'(rd_data), 32'hBEEF);
        chk("wr_fetch", 32'(fetch_data), 32'hBEEF);

        step(1'b0, '0, '0, 15'h2805, '0);
        idle();
        chk("miss_hit", 32'(rd_hit), 32'h0);
        chk("miss_data", 32'(rd_data), 32'h0);
        step(1'b1, 15'h2805, 16'hDEAD, '0, '0);
        step(1'b0, '0, '0, 15'h1805, '0);
        idle();
        chk("miss_wr_ignored", 32'(rd_data), 32'hBEEF);

        for (int i = 0; i < 4; i++)
            step(1'b1, 15'(15'h1800 + i), 16'(i + 1), '0, '0);
        for (int i = 0; i < 5; i++) begin
            if (i < 4) step(1'b0, '0, '0, 15'(15'h1800 + i), '0);
            else idle();
            if (i >= 1) chk("pipelined", 32'(rd_data), 32'(i));
        end

        step(1'b1, 15'h1810, 16'h0001, '0, '0);
        step(1'b0, '0, '0, 15'h1810, 15'h1810);
        step(1'b1, 15'h1810, 16'h0002, '0, '0);
        chk("collide_rd", 32'(rd_data), BYPASS ? 32'h2 : 32'h1);
        chk("collide_fetch", 32'(fetch_data), BYPASS ? 32'h2 : 32'h1);
        step(1'b0, '0, '0, 15'h1810, '0);
        idle();
        chk("collide_later", 32'(rd_data), 32'h2);

        repeat (500) rnd_step();

        step(1'b0, '0, '0, 15'h1805, '0);
        idle();
        do_reset();

        repeat (100) rnd_step();
        do_reset();
        wait_ready("ready_after_midclear", 0);
        step(1'b0, '0, '0, 15'h1805, 15'h1810);
        idle();
        chk("swept_rd", 32'(rd_data), 32'h0);
        chk("swept_fetch", 32'(fetch_data), 32'h0);

        repeat (300) rnd_step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
